// File: rtl/spi_register_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : spi_register_dispatcher
// Description : Decodes 8-bit SPI commands into register reads/writes against
//               a small register bank (ID, STATUS, control registers), with
//               bad-address, read-only-write and stalled-transaction detection.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                  : system clock
//   reset                : synchronous, active-high reset
//   spi_command          : [7] 1=write/0=read, [6:0] register address
//   spi_command_ready    : one-cycle pulse, spi_command valid
//   spi_word_received    : data word from the SPI master
//   spi_word_rx_complete : one-cycle pulse, spi_word_received valid
//   spi_word_to_output   : combinational read data for the slave to stage
//   status_in            : design status, shown in STATUS[15:0]
//   ctrl_regs            : control registers packed, addr 2 in bits [31:0]
//   ctrl_write_strobe    : one-cycle pulse per control register written
//   busy                 : high whenever a transaction is pending
// Configuration macro:
//   SPI_DISPATCH_COUNTERS_EN : when defined, builds the 8-bit saturating
//                              error/abort counters shown in STATUS[31:16];
//                              otherwise STATUS[31:16] reads zero.
// ============================================================================
module spi_register_dispatcher #(
    parameter int          NUM_REGS       = 8,
    parameter logic [31:0] ID_VALUE       = 32'h5049_4356,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 spi_command,
    input  logic                       spi_command_ready,
    input  logic [31:0]                spi_word_received,
    input  logic                       spi_word_rx_complete,
    output logic [31:0]                spi_word_to_output,
    input  logic [15:0]                status_in,
    output logic [32*(NUM_REGS-2)-1:0] ctrl_regs,
    output logic [NUM_REGS-3:0]        ctrl_write_strobe,
    output logic                       busy
);

    localparam int C_NUM_CTRL = NUM_REGS - 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]            r_state;
    logic [7:0]            r_cmd;
    logic [15:0]           r_timer;
    logic [31:0]           r_regs [C_NUM_CTRL];
    logic [C_NUM_CTRL-1:0] r_strobe;

    logic [31:0] w_rd_addr;
    logic [31:0] w_cmd_addr;
    logic        w_new_valid;
    logic        w_timeout;
    logic        w_do_write;
    logic        w_err_inc;
    logic        w_abort_inc;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;

    // Addresses widened to 32 bits so they compare cleanly with int params.
    assign w_rd_addr   = {25'd0, spi_command[6:0]};
    assign w_cmd_addr  = {25'd0, r_cmd[6:0]};
    assign w_new_valid = (w_rd_addr < NUM_REGS);
    assign w_timeout   = (r_timer == 16'(TIMEOUT_CYCLES - 1));
    // Only writes to control addresses commit; addr < NUM_REGS is known
    // because out-of-range commands never reach ARMED.
    assign w_do_write  = r_cmd[7] && (w_cmd_addr >= 32'd2);

    // ------------------------------------------------------------------
    // Event detection feeding the error/abort counters
    // ------------------------------------------------------------------
    always_comb begin
        w_err_inc   = 1'b0;
        w_abort_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (spi_command_ready && !w_new_valid) w_err_inc = 1'b1;
            end
            S_ARMED, S_DISCARD: begin
                if (spi_command_ready) begin
                    // A new command abandons the pending one.
                    w_abort_inc = 1'b1;
                    if (!w_new_valid) w_err_inc = 1'b1;
                end else if (spi_word_rx_complete) begin
                    // rx_complete beats a coincident timeout.
                    if (r_state == S_ARMED && r_cmd[7] && !w_do_write) w_err_inc = 1'b1;
                end else if (w_timeout) begin
                    w_abort_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction FSM and register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cmd    <= 8'd0;
            r_timer  <= 16'd0;
            r_strobe <= '0;
            for (int i = 0; i < C_NUM_CTRL; i++) r_regs[i] <= 32'd0;
        end else begin
            r_strobe <= '0;
            case (r_state)
                S_IDLE: begin
                    if (spi_command_ready) begin
                        r_cmd   <= spi_command;
                        r_timer <= 16'd0;
                        r_state <= w_new_valid ? S_ARMED : S_DISCARD;
                    end
                end
                S_ARMED, S_DISCARD: begin
                    if (spi_command_ready) begin
                        r_cmd   <= spi_command;
                        r_timer <= 16'd0;
                        r_state <= w_new_valid ? S_ARMED : S_DISCARD;
                    end else if (spi_word_rx_complete) begin
                        r_state <= S_IDLE;
                        if (r_state == S_ARMED && w_do_write) begin
                            for (int i = 0; i < C_NUM_CTRL; i++) begin
                                if (w_cmd_addr == 32'(i + 2)) begin
                                    r_regs[i]   <= spi_word_received;
                                    r_strobe[i] <= 1'b1;
                                end
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_timer <= 16'd0;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional diagnostic counters
    // ------------------------------------------------------------------
`ifdef SPI_DISPATCH_COUNTERS_EN
    logic [7:0] r_err_cnt;
    logic [7:0] r_abort_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt   <= 8'd0;
            r_abort_cnt <= 8'd0;
        end else begin
            if (w_err_inc && r_err_cnt != 8'hFF)     r_err_cnt   <= r_err_cnt + 8'd1;
            if (w_abort_inc && r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 8'd1;
        end
    end

    assign w_status = {r_abort_cnt, r_err_cnt, status_in};
`else
    logic w_unused_inc;
    assign w_unused_inc = w_err_inc ^ w_abort_inc;
    assign w_status     = {16'd0, status_in};
`endif

    // ------------------------------------------------------------------
    // Zero-latency read mux; out-of-range addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 32'd0;
        if (w_rd_addr == 32'd0) begin
            w_rd_data = ID_VALUE;
        end else if (w_rd_addr == 32'd1) begin
            w_rd_data = w_status;
        end else begin
            for (int i = 0; i < C_NUM_CTRL; i++) begin
                if (w_rd_addr == 32'(i + 2)) w_rd_data = r_regs[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < C_NUM_CTRL; g++) begin : g_pack
            assign ctrl_regs[g*32 +: 32] = r_regs[g];
        end
    endgenerate

    assign spi_word_to_output = w_rd_data;
    assign ctrl_write_strobe  = r_strobe;
    assign busy               = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_register_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_register_dispatcher
// Description : Directed self-checking bench for spi_register_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_register_dispatcher;

    localparam int NR = 8;
    localparam int TO = 16;
    localparam int NC = NR - 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      spi_command = 8'd0;
    logic            spi_command_ready = 1'b0;
    logic [31:0]     spi_word_received = 32'd0;
    logic            spi_word_rx_complete = 1'b0;
    logic [31:0]     spi_word_to_output;
    logic [15:0]     status_in = 16'hA5C3;
    logic [32*NC-1:0] ctrl_regs;
    logic [NC-1:0]   ctrl_write_strobe;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [32*NC-1:0] exp_ctrl  = '0;
    logic [7:0]       exp_err   = 8'd0;
    logic [7:0]       exp_abort = 8'd0;

    always #5 clk = ~clk;

    spi_register_dispatcher #(
        .NUM_REGS      (NR),
        .ID_VALUE      (32'h5049_4356),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .spi_command         (spi_command),
        .spi_command_ready   (spi_command_ready),
        .spi_word_received   (spi_word_received),
        .spi_word_rx_complete(spi_word_rx_complete),
        .spi_word_to_output  (spi_word_to_output),
        .status_in           (status_in),
        .ctrl_regs           (ctrl_regs),
        .ctrl_write_strobe   (ctrl_write_strobe),
        .busy                (busy)
    );

    function automatic logic [31:0] exp_status();
`ifdef SPI_DISPATCH_COUNTERS_EN
        return {exp_abort, exp_err, status_in};
`else
        return {16'd0, status_in};
`endif
    endfunction

    // Both drivers return 1ns after the edge that samples the pulse.
    task automatic pulse_cmd(input logic [7:0] c);
        @(negedge clk);
        spi_command       = c;
        spi_command_ready = 1'b1;
        @(posedge clk);
        #1;
        spi_command_ready = 1'b0;
    endtask

    task automatic pulse_word(input logic [31:0] w);
        @(negedge clk);
        spi_word_received    = w;
        spi_word_rx_complete = 1'b1;
        @(posedge clk);
        #1;
        spi_word_rx_complete = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_ctrl  = '0;
        exp_err   = 8'd0;
        exp_abort = 8'd0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (ctrl_regs !== exp_ctrl) begin bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl_regs, exp_ctrl); end
        total++;
        if (ctrl_write_strobe !== '0) begin bad++; $display("FAIL reset_strobe: got %b want 0", ctrl_write_strobe); end
        spi_command = 8'h01;
        #1;
        total++;
        if (spi_word_to_output !== 32'h0000_A5C3) begin bad++; $display("FAIL reset_status: got %h want %h", spi_word_to_output, 32'h0000_A5C3); end
    endtask

    task automatic test_write();
        pulse_cmd(8'h82);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
        pulse_word(32'hDEAD_BEEF);
        exp_ctrl[31:0] = 32'hDEAD_BEEF;
        total++;
        if (ctrl_regs !== exp_ctrl) begin bad++; $display("FAIL write_reg2: got %h want %h", ctrl_regs, exp_ctrl); end
        total++;
        if (ctrl_write_strobe !== 6'b000001) begin bad++; $display("FAIL write_strobe2: got %b want 000001", ctrl_write_strobe); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL write_idle: got %b want 0", busy); end
        @(posedge clk); #1;
        total++;
        if (ctrl_write_strobe !== 6'b000000) begin bad++; $display("FAIL write_strobe_drop: got %b want 000000", ctrl_write_strobe); end
        // Highest control address.
        pulse_cmd(8'h87);
        pulse_word(32'h1234_5678);
        exp_ctrl[191:160] = 32'h1234_5678;
        total++;
        if (ctrl_regs !== exp_ctrl) begin bad++; $display("FAIL write_reg7: got %h want %h", ctrl_regs, exp_ctrl); end
        total++;
        if (ctrl_write_strobe !== 6'b100000) begin bad++; $display("FAIL write_strobe7: got %b want 100000", ctrl_write_strobe); end
    endtask

    task automatic test_read();
        @(negedge clk);
        spi_command       = 8'h02;
        spi_command_ready = 1'b1;
        #1;
        total++;
        if (spi_word_to_output !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_reg2: got %h want DEADBEEF", spi_word_to_output); end
        @(posedge clk); #1;
        spi_command_ready = 1'b0;
        pulse_word(32'hFFFF_0000);
        total++;
        if (ctrl_write_strobe !== '0 || ctrl_regs !== exp_ctrl || busy !== 1'b0) begin
            bad++; $display("FAIL read_no_write: strobe=%b busy=%b regs=%h want regs=%h", ctrl_write_strobe, busy, ctrl_regs, exp_ctrl);
        end
        spi_command = 8'h00; #1;
        total++;
        if (spi_word_to_output !== 32'h5049_4356) begin bad++; $display("FAIL read_id: got %h want 50494356", spi_word_to_output); end
        spi_command = 8'h07; #1;
        total++;
        if (spi_word_to_output !== 32'h1234_5678) begin bad++; $display("FAIL read_reg7: got %h want 12345678", spi_word_to_output); end
        spi_command = 8'h08; #1;
        total++;
        if (spi_word_to_output !== 32'd0) begin bad++; $display("FAIL read_addr8: got %h want 0", spi_word_to_output); end
    endtask

    task automatic test_bad_addr();
        @(negedge clk);
        spi_command       = 8'h7F;
        spi_command_ready = 1'b1;
        #1;
        total++;
        if (spi_word_to_output !== 32'd0) begin bad++; $display("FAIL bad_addr_out: got %h want 0", spi_word_to_output); end
        @(posedge clk); #1;
        spi_command_ready = 1'b0;
        exp_err++;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL bad_addr_busy: got %b want 1", busy); end
        pulse_word(32'hCAFE_F00D);
        total++;
        if (ctrl_write_strobe !== '0 || ctrl_regs !== exp_ctrl || busy !== 1'b0) begin
            bad++; $display("FAIL bad_addr_drop: strobe=%b busy=%b regs=%h", ctrl_write_strobe, busy, ctrl_regs);
        end
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL bad_addr_status: got %h want %h", spi_word_to_output, exp_status()); end
    endtask

    task automatic test_ro_write();
        pulse_cmd(8'h81);
        pulse_word(32'h1111_1111);
        exp_err++;
        total++;
        if (ctrl_write_strobe !== '0 || ctrl_regs !== exp_ctrl) begin
            bad++; $display("FAIL ro_write1: strobe=%b regs=%h want %h", ctrl_write_strobe, ctrl_regs, exp_ctrl);
        end
        pulse_cmd(8'h80);
        pulse_word(32'h2222_2222);
        exp_err++;
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL ro_write_status: got %h want %h", spi_word_to_output, exp_status()); end
        spi_command = 8'h00; #1;
        total++;
        if (spi_word_to_output !== 32'h5049_4356) begin bad++; $display("FAIL ro_write_id: got %h want 50494356", spi_word_to_output); end
    endtask

    task automatic test_timeout();
        pulse_cmd(8'h83);
        repeat (TO - 1) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early: got %b want 1", busy); end
        @(posedge clk); #1;
        exp_abort++;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL timeout_expire: got %b want 0", busy); end
        pulse_word(32'h3333_3333);
        total++;
        if (ctrl_write_strobe !== '0 || ctrl_regs !== exp_ctrl) begin
            bad++; $display("FAIL timeout_late_word: strobe=%b regs=%h want %h", ctrl_write_strobe, ctrl_regs, exp_ctrl);
        end
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL timeout_status: got %h want %h", spi_word_to_output, exp_status()); end
    endtask

    task automatic test_rx_wins();
        // rx_complete lands on the very edge the timeout would fire.
        pulse_cmd(8'h84);
        repeat (TO - 1) @(posedge clk);
        pulse_word(32'h4444_4444);
        exp_ctrl[95:64] = 32'h4444_4444;
        total++;
        if (ctrl_regs !== exp_ctrl || ctrl_write_strobe !== 6'b000100) begin
            bad++; $display("FAIL rx_wins_write: strobe=%b regs=%h want strobe=000100 regs=%h", ctrl_write_strobe, ctrl_regs, exp_ctrl);
        end
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL rx_wins_status: got %h want %h", spi_word_to_output, exp_status()); end
    endtask

    task automatic test_preempt();
        pulse_cmd(8'h85);
        // New command with a coincident rx_complete: word must be ignored.
        @(negedge clk);
        spi_command          = 8'h86;
        spi_command_ready    = 1'b1;
        spi_word_received    = 32'hBAD0_BAD0;
        spi_word_rx_complete = 1'b1;
        @(posedge clk); #1;
        spi_command_ready    = 1'b0;
        spi_word_rx_complete = 1'b0;
        exp_abort++;
        total++;
        if (ctrl_write_strobe !== '0 || busy !== 1'b1 || ctrl_regs !== exp_ctrl) begin
            bad++; $display("FAIL preempt_hold: strobe=%b busy=%b regs=%h want %h", ctrl_write_strobe, busy, ctrl_regs, exp_ctrl);
        end
        pulse_word(32'h600D_600D);
        exp_ctrl[159:128] = 32'h600D_600D;
        total++;
        if (ctrl_regs !== exp_ctrl || ctrl_write_strobe !== 6'b010000) begin
            bad++; $display("FAIL preempt_write: strobe=%b regs=%h want strobe=010000 regs=%h", ctrl_write_strobe, ctrl_regs, exp_ctrl);
        end
        // Preempt with an out-of-range command: abort and error together.
        pulse_cmd(8'h85);
        pulse_cmd(8'h90);
        exp_abort++;
        exp_err++;
        pulse_word(32'h5555_5555);
        total++;
        if (ctrl_write_strobe !== '0 || ctrl_regs !== exp_ctrl || busy !== 1'b0) begin
            bad++; $display("FAIL preempt_bad: strobe=%b busy=%b regs=%h", ctrl_write_strobe, busy, ctrl_regs);
        end
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL preempt_status: got %h want %h", spi_word_to_output, exp_status()); end
    endtask

    task automatic test_rx_idle();
        pulse_word(32'h6666_6666);
        total++;
        if (ctrl_write_strobe !== '0 || busy !== 1'b0 || ctrl_regs !== exp_ctrl) begin
            bad++; $display("FAIL rx_idle: strobe=%b busy=%b regs=%h", ctrl_write_strobe, busy, ctrl_regs);
        end
    endtask

    task automatic test_reset_mid();
        pulse_cmd(8'h82);
        do_reset();
        pulse_word(32'h7777_7777);
        total++;
        if (ctrl_regs !== '0 || ctrl_write_strobe !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid: strobe=%b busy=%b regs=%h want all 0", ctrl_write_strobe, busy, ctrl_regs);
        end
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL reset_mid_status: got %h want %h", spi_word_to_output, exp_status()); end
        // Bad address after reset: upper STATUS depends only on the build.
        pulse_cmd(8'h7F);
        exp_err++;
        pulse_word(32'h8888_8888);
        spi_command = 8'h01; #1;
        total++;
        if (spi_word_to_output !== exp_status()) begin bad++; $display("FAIL post_reset_status: got %h want %h", spi_word_to_output, exp_status()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_ro_write();
        test_timeout();
        test_rx_wins();
        test_preempt();
        test_rx_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
